// File: rtl/mode_ctrl.sv
// Mode controller: debounced mode/set buttons, RUN/SET_HOUR/SET_MIN FSM.
// Define MODE_CTRL_AUTO_REPEAT_EN to repeat change pulses on a held set.
module mode_ctrl #(
  parameter int DB_CYCLES     = 16,
  parameter int TIMEOUT_TICKS = 10,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       tick,
  output logic [1:0] mode,
  output logic       change,
  output logic       blink
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_e;

  if (DB_CYCLES < 1 || TIMEOUT_TICKS < 1 ||
      REPEAT_CYCLES < 2) begin : g_bad
    $error("mode_ctrl: invalid parameters");
  end

  // bit 0 = mode button, bit 1 = set button
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    db_q, db_d;
  logic [1:0]    dbp_q, dbp_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_e        state_q, state_d;
  logic          change_q, change_d;
  logic          blink_q, blink_d;
  logic [IW-1:0] idle_q, idle_d;

  logic          mode_ev;
  logic          set_ev;
  logic          in_set;
  logic          rep_hit;

  // Synchronizer chains, debounce counters and levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      dbp_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      dbp_q    <= dbp_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Level flips after DB_CYCLES differing samples in a row
  always_comb begin
    sync1_d = {btn_set, btn_mode};
    sync2_d = sync1_q;
    dbp_d   = db_q;
    db_d    = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign mode_ev = db_q[0] & ~dbp_q[0];
  assign set_ev  = db_q[1] & ~dbp_q[1];
  assign in_set  = (state_q != RUN);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: mode event advances, idle timeout falls back to RUN
  always_comb begin
    logic   tmo;
    state_e adv;
    tmo = in_set & (idle_q == IW'(TIMEOUT_TICKS)) &
          ~mode_ev & ~set_ev;
    unique case (state_q)
      RUN:      adv = SET_HOUR;
      SET_HOUR: adv = SET_MIN;
      default:  adv = RUN;
    endcase
    state_d = state_q;
    unique case (1'b1)
      mode_ev: state_d = adv;
      tmo:     state_d = RUN;
      default: ;
    endcase
  end

  // Output and idle registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_q <= 1'b0;
      blink_q  <= 1'b0;
      idle_q   <= '0;
    end else begin
      change_q <= change_d;
      blink_q  <= blink_d;
      idle_q   <= idle_d;
    end
  end

  // Change pulse, blink phase and idle count for the next cycle
  always_comb begin
    logic enter;
    enter    = (state_d != RUN) && (state_d != state_q);
    change_d = in_set & ~mode_ev & (set_ev | rep_hit);
    if (state_d == RUN) begin
      blink_d = 1'b0;
    end else if (enter) begin
      blink_d = 1'b1;
    end else if (tick) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
    if (state_d == RUN || enter || mode_ev ||
        set_ev || rep_hit) begin
      idle_d = '0;
    end else if (tick) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = idle_q;
    end
  end

`ifdef MODE_CTRL_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  logic [RW-1:0] rep_q, rep_d;

  // Repeat interval counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end

  // Counts while set stays held in a SET state
  always_comb begin
    rep_d   = '0;
    rep_hit = 1'b0;
    if (!set_ev && db_q[1] && in_set) begin
      if (rep_q == RW'(REPEAT_CYCLES - 1)) begin
        rep_hit = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  assign mode   = state_q;
  assign change = change_q;
  assign blink  = blink_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Self-checking bench for mode_ctrl against a per-cycle behavioural model.
// Honours MODE_CTRL_AUTO_REPEAT_EN in its expectations.
module tb_mode_ctrl;

  localparam int DB  = 16;
  localparam int TO  = 10;
  localparam int REP = 8;

  logic       clk;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_set;
  logic       tick;
  logic [1:0] mode;
  logic       change;
  logic       blink;

  int ncomp = 0;
  int nfail = 0;

  mode_ctrl #(
    .DB_CYCLES    (DB),
    .TIMEOUT_TICKS(TO),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_set (btn_set),
    .tick    (tick),
    .mode    (mode),
    .change  (change),
    .blink   (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // raw button history, index 0 = value sampled at latest edge
  bit qm[$];
  bit qs[$];
  bit m_dbm, m_dbs, m_mev, m_sev;
  int m_mode, m_idle, m_rep;
  bit m_change, m_blink;

  task automatic model_reset();
    qm.delete();
    qs.delete();
    for (int k = 0; k < DB + 2; k++) begin
      qm.push_back(1'b0);
      qs.push_back(1'b0);
    end
    m_dbm = 0; m_dbs = 0; m_mev = 0; m_sev = 0;
    m_mode = 0; m_idle = 0; m_rep = 0;
    m_change = 0; m_blink = 0;
  endtask

  // level flips when the last DB synchronized samples all differ from it
  function automatic bit win_diff(input bit which, input bit lvl);
    bit v;
    for (int k = 2; k < DB + 2; k++) begin
      v = which ? qs[k] : qm[k];
      if (v == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input bit m, input bit s, input bit t);
    bit in_set, rep_hit, enter, nm, ns;
    int nmode;
    in_set  = (m_mode != 0);
    rep_hit = 0;
`ifdef MODE_CTRL_AUTO_REPEAT_EN
    if (!m_sev && m_dbs && in_set) begin
      m_rep++;
      if (m_rep == REP) begin
        rep_hit = 1;
        m_rep = 0;
      end
    end else begin
      m_rep = 0;
    end
`endif
    if (m_mev) nmode = (m_mode + 1) % 3;
    else if (in_set && m_idle == TO && !m_sev) nmode = 0;
    else nmode = m_mode;
    m_change = in_set && !m_mev && (m_sev || rep_hit);
    enter = (nmode != 0) && (nmode != m_mode);
    if (nmode == 0) m_blink = 0;
    else if (enter) m_blink = 1;
    else if (t) m_blink = ~m_blink;
    if (nmode == 0 || enter || m_mev || m_sev || rep_hit) m_idle = 0;
    else if (t) m_idle++;
    m_mode = nmode;
    qm.push_front(m);
    qs.push_front(s);
    void'(qm.pop_back());
    void'(qs.pop_back());
    nm = win_diff(1'b0, m_dbm) ? ~m_dbm : m_dbm;
    ns = win_diff(1'b1, m_dbs) ? ~m_dbs : m_dbs;
    m_mev = nm & ~m_dbm;
    m_sev = ns & ~m_dbs;
    m_dbm = nm;
    m_dbs = ns;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit m, input bit s, input bit t);
    btn_mode = m;
    btn_set  = s;
    tick     = t;
    @(posedge clk);
    model_edge(m, s, t);
    #1;
    chk("model_mode", {6'd0, mode}, 8'(m_mode));
    chk("model_change", {7'd0, change}, {7'd0, m_change});
    chk("model_blink", {7'd0, blink}, {7'd0, m_blink});
  endtask

  task automatic run(input int n, input bit m, input bit s,
                     input bit t, output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      step(m, s, t);
      if (change === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mode", {6'd0, mode}, 8'd0);
    chk("rst_change", {7'd0, change}, 8'd0);
    chk("rst_blink", {7'd0, blink}, 8'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int c1, c2, f1, f2, exp_n;
    bit rm, rs;
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_set  = 1'b0;
    tick     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_mode", {6'd0, mode}, 8'd0);
    chk("init_change", {7'd0, change}, 8'd0);
    chk("init_blink", {7'd0, blink}, 8'd0);
    #3 rst_n = 1'b1;

    // mode press: SET_HOUR exactly 19 edges after the raw edge
    run(18, 1, 0, 0, c1, f1);
    chk("mode_at_18", {6'd0, mode}, 8'd0);
    run(1, 1, 0, 0, c1, f1);
    chk("mode_at_19", {6'd0, mode}, 8'd1);
    chk("blink_entry", {7'd0, blink}, 8'd1);
    run(20, 0, 0, 0, c1, f1);

    // short set press is filtered
    run(10, 0, 1, 0, c1, f1);
    run(25, 0, 0, 0, c2, f2);
    chk("short_press_pulses", 8'(c1 + c2), 8'd0);

    // long set press: one pulse at edge 19
    run(20, 0, 1, 0, c1, f1);
    run(30, 0, 0, 0, c2, f2);
    chk("set_pulse_edge", 8'(f1), 8'd19);
`ifdef MODE_CTRL_AUTO_REPEAT_EN
    exp_n = 3;
`else
    exp_n = 1;
`endif
    chk("set_pulse_count", 8'(c1 + c2), 8'(exp_n));

    // simultaneous mode+set: transition, no pulse
    run(18, 1, 1, 0, c1, f1);
    run(1, 1, 1, 0, c1, f1);
    chk("both_mode", {6'd0, mode}, 8'd2);
    chk("both_change", {7'd0, change}, 8'd0);
    run(30, 0, 0, 0, c1, f1);

    // idle timeout in SET_MIN
    for (int i = 1; i <= TO; i++) begin
      run(1, 0, 0, 1, c1, f1);
      if (i < TO) run(2, 0, 0, 0, c1, f1);
    end
    chk("tmo_before", {6'd0, mode}, 8'd2);
    run(1, 0, 0, 0, c1, f1);
    chk("tmo_mode", {6'd0, mode}, 8'd0);
    chk("tmo_blink", {7'd0, blink}, 8'd0);

    // set in RUN is ignored
    run(20, 0, 1, 0, c1, f1);
    run(25, 0, 0, 0, c2, f2);
    chk("run_set_pulses", 8'(c1 + c2), 8'd0);
    chk("run_set_mode", {6'd0, mode}, 8'd0);

    // held set in SET_HOUR (auto-repeat when enabled)
    run(20, 1, 0, 0, c1, f1);
    run(20, 0, 0, 0, c1, f1);
    chk("rep_setup_mode", {6'd0, mode}, 8'd1);
    run(48, 0, 1, 0, c1, f1);
    run(30, 0, 0, 0, c2, f2);
`ifdef MODE_CTRL_AUTO_REPEAT_EN
    exp_n = 6;
`else
    exp_n = 1;
`endif
    chk("hold_pulse_count", 8'(c1 + c2), 8'(exp_n));

    // reset mid-press: full debounce needed after release
    run(10, 1, 0, 0, c1, f1);
    do_reset();
    run(18, 1, 0, 0, c1, f1);
    chk("rst_press_18", {6'd0, mode}, 8'd0);
    run(1, 1, 0, 0, c1, f1);
    chk("rst_press_19", {6'd0, mode}, 8'd1);
    run(25, 0, 0, 0, c1, f1);

    // random buttons, ticks and occasional resets
    rm = 0;
    rs = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(11) == 0) rm = ~rm;
      if ($urandom_range(9) == 0) rs = ~rs;
      if ($urandom_range(599) == 0) do_reset();
      step(rm, rs, $urandom_range(3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/mode_ctrl.md
MODE_CTRL -- requirements
Module: mode_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 16; number of consecutive stable synchronized samples that qualify a button level change.
REQ-002 Parameter TIMEOUT_TICKS, default 10; count of tick pulses without a button event that returns the block to RUN.
REQ-003 Parameter REPEAT_CYCLES, default 8; auto-repeat interval in clk cycles, used only with AUTO_REPEAT_EN.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn_mode  input  1  raw mode push-button, asynchronous, active-high.
REQ-007 btn_set  input  1  raw set push-button, asynchronous, active-high.
REQ-008 tick  input  1  one-cycle, clk-synchronous enable pulse, nominally 1 Hz.
REQ-009 mode  output  2  current mode: 00 RUN, 01 SET_HOUR, 10 SET_MIN; registered.
REQ-010 change  output  1  one-cycle step pulse to the clock/step selector; registered.
REQ-011 blink  output  1  display blink enable; registered.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer and then a debouncer whose counter clears when the synchronized value equals the debounced level, and whose debounced level flips once DB_CYCLES consecutive differing samples are seen.
REQ-013 A debounced rising edge SHALL produce an internal one-cycle event; a raw press held stable SHALL affect outputs exactly DB_CYCLES+3 clk cycles after the raw edge.
REQ-014 A press shorter than DB_CYCLES cycles SHALL produce no event.
REQ-015 FSM transitions on a mode event: RUN->SET_HOUR->SET_MIN->RUN; mode SHALL never be 11.
REQ-016 A set event in SET_HOUR or SET_MIN SHALL produce exactly one change pulse; set events in RUN SHALL be ignored.
REQ-017 A mode event and a set event in the same cycle: mode transition taken, change suppressed.
REQ-018 The idle counter SHALL clear on any button event and on entry to a SET state, and increment on each tick while in a SET state.
REQ-019 When the idle counter reaches TIMEOUT_TICKS, the FSM SHALL return to RUN on the next clk edge and the idle counter SHALL clear; a button event in that same cycle takes precedence over the timeout.
REQ-020 blink SHALL be 0 in RUN, SHALL be 1 on entry to a SET state, and SHALL toggle on each tick while in a SET state.
REQ-021 tick SHALL be ignored in RUN except that it has no effect on any state.

Reset
REQ-022 On rst_n low, mode=00, change=0, and blink=0 SHALL take effect immediately; the synchronizers, debounced levels, and all counters SHALL clear.
REQ-023 A reset asserted mid-press SHALL discard the press; after release, a still-held button SHALL generate an event only after a full debounce period.

Configuration
REQ-024 Macro MODE_CTRL_AUTO_REPEAT_EN defined: while debounced btn_set stays high in a SET state, an extra change pulse SHALL be emitted every REPEAT_CYCLES cycles after the initial pulse, and each repeat SHALL clear the idle counter.
REQ-025 Macro undefined: exactly one change pulse per press, and the repeat counter logic SHALL be absent.

Verification
REQ-026 Reset, then btn_mode high held for 20 cycles (DB_CYCLES=16) -> mode=01 at cycle 19 after the raw edge, and blink=1.
REQ-027 btn_set pulsed high for 10 cycles in SET_HOUR -> no change pulse; held for 20 cycles -> exactly one change pulse, 19 cycles after the raw edge.
REQ-028 In RUN, btn_set pressed -> change stays 0 and mode stays 00.
REQ-029 In SET_MIN, 10 ticks with no press -> mode=00 one cycle after the 10th tick, and blink=0.
REQ-030 btn_mode and btn_set raised on the same cycle in SET_HOUR -> mode=10 and no change pulse.
REQ-031 With the macro defined and btn_set held for 40 cycles past qualification (REPEAT_CYCLES=8) -> 1+5 change pulses spaced 8 cycles apart; with the macro undefined -> 1 pulse.
